bias_row_unit: RTL and testbench

- Multi-column successor to the single-lane bias adder.
- Adds a per-column bias to each of NUM_COLS systolic result lanes with 1-cycle latency and independent per-lane valids, so skewed systolic drain is supported.
- Biases come from a double-buffered (shadow/active) bank. The shadow bank is loaded serially through a valid/ready port while the active bank serves traffic.
- A runtime mode selects saturating or wrapping addition. The block sits between the systolic array drain and the post-processing stage.

---
 rtl/bias_pkg.sv | 29 ++
 rtl/bias_lane.sv | 70 +++++++
 rtl/bias_row_unit.sv | 112 +++++++++++
 tb/tb_bias_row_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_pkg.sv
// rtl/bias_pkg.sv - shared types and helpers for the bias row unit
//   Provides the load FSM state enum, saturation bound helpers and the
//   bias-bank pointer width helper.
package bias_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2
  } load_state_e;

  // Bounds are returned 64 bits wide; callers keep the low `width` bits.
  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int width);
    return ~sat_max(width);
  endfunction

  // Pointer width for a bank of n words, never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_NUM_COLS = 4;
  localparam int DEFAULT_PTR_W    = ptr_width(DEFAULT_NUM_COLS);

endpackage

// File: rtl/bias_lane.sv
// rtl/bias_lane.sv - one lane: registered bias add with optional saturation
//   clk, rst         : clock, synchronous active-high reset
//   valid_in         : lane data valid; data/flag registers load only when set
//   sat_en_in        : 1 = clamp on overflow, 0 = wrap
//   data_in, bias_in : signed operands, DATA_WIDTH bits each
//   data_out         : registered result
//   flag_out         : registered clamp indicator
//   valid_out        : valid_in delayed by one cycle
module bias_lane
  import bias_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic                  sat_en_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] bias_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  flag_out,
  output logic                  valid_out
);

  localparam logic [63:0]           MAX64 = sat_max(DATA_WIDTH);
  localparam logic [63:0]           MIN64 = sat_min(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MAX_V = MAX64[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] MIN_V = MIN64[DATA_WIDTH-1:0];

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  flag_d, flag_q;
  logic                  valid_d, valid_q;

  always_comb begin
    sum     = {data_in[DATA_WIDTH-1], data_in} + {bias_in[DATA_WIDTH-1], bias_in};
    data_d  = data_q;
    flag_d  = flag_q;
    valid_d = valid_in;
    if (valid_in) begin
      // The two top bits of the widened sum differ exactly when the true
      // result falls outside the DATA_WIDTH signed range; the extra bit
      // gives the direction.
      if (sat_en_in && (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])) begin
        data_d = sum[DATA_WIDTH] ? MIN_V : MAX_V;
        flag_d = 1'b1;
      end else begin
        data_d = sum[DATA_WIDTH-1:0];
        flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      flag_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      flag_q  <= flag_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign flag_out  = flag_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/bias_row_unit.sv
// rtl/bias_row_unit.sv - per-column bias adder with double-buffered bias bank
//   clk, rst            : clock, synchronous active-high reset
//   bias_load_*         : serial valid/ready load of the shadow bank, column 0 first
//   bias_load_done_out  : shadow bank complete, waiting for a swap
//   bias_swap_in        : copy shadow to active (only honoured when complete)
//   bias_sat_en_in      : saturating (1) or wrapping (0) add
//   bias_sys_*_in       : packed lane data and per-lane valids
//   bias_z_data_out, bias_Z_valid_out, bias_sat_flag_out : registered lane results
module bias_row_unit
  import bias_pkg::*;
#(
  parameter int NUM_COLS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BIAS_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           bias_load_valid_in,
  input  logic [BIAS_WIDTH-1:0]          bias_load_data_in,
  output logic                           bias_load_ready_out,
  output logic                           bias_load_done_out,
  input  logic                           bias_swap_in,
  input  logic                           bias_sat_en_in,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] bias_sys_data_in,
  input  logic [NUM_COLS-1:0]            bias_sys_valid_in,
  output logic [NUM_COLS*DATA_WIDTH-1:0] bias_z_data_out,
  output logic [NUM_COLS-1:0]            bias_Z_valid_out,
  output logic [NUM_COLS-1:0]            bias_sat_flag_out
);

  localparam int PTR_W = ptr_width(NUM_COLS);

  load_state_e                          state_d, state_q;
  logic [PTR_W-1:0]                     ptr_d, ptr_q;
  logic [NUM_COLS-1:0][BIAS_WIDTH-1:0]  shadow_d, shadow_q;
  logic [NUM_COLS-1:0][BIAS_WIDTH-1:0]  active_d, active_q;
  logic                                 accept;

  always_comb begin
    state_d             = state_q;
    ptr_d               = ptr_q;
    shadow_d            = shadow_q;
    active_d            = active_q;
    bias_load_ready_out = 1'b0;
    bias_load_done_out  = 1'b0;
    accept              = 1'b0;

    case (state_q)
      ST_IDLE, ST_LOADING: begin
        bias_load_ready_out = 1'b1;
        accept              = bias_load_valid_in;
        if (accept) begin
          shadow_d[ptr_q] = bias_load_data_in;
          if (ptr_q == PTR_W'(NUM_COLS - 1)) begin
            ptr_d   = '0;
            state_d = ST_FULL;
          end else begin
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = ST_LOADING;
          end
        end
      end
      ST_FULL: begin
        bias_load_done_out = 1'b1;
        // Lanes sample active_q on this same edge, so data arriving with
        // the swap still sees the old biases.
        if (bias_swap_in) begin
          active_d = shadow_q;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
    logic [DATA_WIDTH-1:0] bias_ext;
    assign bias_ext = DATA_WIDTH'($signed(active_q[c]));

    bias_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .valid_in (bias_sys_valid_in[c]),
      .sat_en_in(bias_sat_en_in),
      .data_in  (bias_sys_data_in[c*DATA_WIDTH +: DATA_WIDTH]),
      .bias_in  (bias_ext),
      .data_out (bias_z_data_out[c*DATA_WIDTH +: DATA_WIDTH]),
      .flag_out (bias_sat_flag_out[c]),
      .valid_out(bias_Z_valid_out[c])
    );
  end

endmodule

// File: tb/tb_bias_row_unit.sv
// tb/tb_bias_row_unit.sv - self-checking bench for bias_row_unit
module tb_bias_row_unit;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          lvalid;
  logic [31:0]   ldata;
  logic          lready;
  logic          ldone;
  logic          swap;
  logic          sat_en;
  logic [127:0]  sys_data;
  logic [3:0]    sys_valid;
  logic [127:0]  z_data;
  logic [3:0]    z_valid;
  logic [3:0]    z_flag;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  longint      m_active [N];
  longint      m_shadow [N];
  int          m_cnt;
  bit          m_full;
  logic [31:0] m_z [N];
  logic [3:0]  m_v;
  logic [3:0]  m_f;

  bias_row_unit #(.NUM_COLS(4), .DATA_WIDTH(32), .BIAS_WIDTH(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .bias_load_valid_in (lvalid),
    .bias_load_data_in  (ldata),
    .bias_load_ready_out(lready),
    .bias_load_done_out (ldone),
    .bias_swap_in       (swap),
    .bias_sat_en_in     (sat_en),
    .bias_sys_data_in   (sys_data),
    .bias_sys_valid_in  (sys_valid),
    .bias_z_data_out    (z_data),
    .bias_Z_valid_out   (z_valid),
    .bias_sat_flag_out  (z_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pack4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [127:0] exp_z();
    logic [127:0] r;
    for (int c = 0; c < N; c++) r[c*32 +: 32] = m_z[c];
    return r;
  endfunction

  // One clock: apply inputs, advance the model by the stated rules, then
  // return at the following falling edge ready for comparisons.
  task automatic step(input logic [3:0] v, input logic [127:0] d,
                      input logic lv, input logic [31:0] ld,
                      input logic sw, input logic sat, input logic r);
    rst = r; sys_valid = v; sys_data = d; lvalid = lv; ldata = ld;
    swap = sw; sat_en = sat;
    if (r) begin
      for (int c = 0; c < N; c++) begin
        m_active[c] = 0; m_shadow[c] = 0; m_z[c] = '0;
      end
      m_cnt = 0; m_full = 0; m_v = '0; m_f = '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (v[c]) begin
          longint s;
          s = longint'($signed(d[c*32 +: 32])) + m_active[c];
          if (sat && s > 64'sd2147483647) begin
            m_z[c] = 32'h7FFF_FFFF; m_f[c] = 1'b1;
          end else if (sat && s < -64'sd2147483648) begin
            m_z[c] = 32'h8000_0000; m_f[c] = 1'b1;
          end else begin
            m_z[c] = s[31:0]; m_f[c] = 1'b0;
          end
        end
      end
      m_v = v;
      if (m_full) begin
        if (sw) begin
          for (int c = 0; c < N; c++) m_active[c] = m_shadow[c];
          m_full = 0;
        end
      end else if (lv) begin
        m_shadow[m_cnt] = longint'($signed(ld));
        m_cnt++;
        if (m_cnt == N) begin
          m_cnt = 0; m_full = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; lvalid = 1'b0; swap = 1'b0; sys_valid = '0;
  endtask

  task automatic load4(input logic [31:0] a, b, c, d);
    step(4'b0, '0, 1'b1, a, 1'b0, 1'b1, 1'b0);
    step(4'b0, '0, 1'b1, b, 1'b0, 1'b1, 1'b0);
    step(4'b0, '0, 1'b1, c, 1'b0, 1'b1, 1'b0);
    step(4'b0, '0, 1'b1, d, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    step(4'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({z_data, z_valid, z_flag, lready, ldone} !== {128'd0, 4'd0, 4'd0, 1'b1, 1'b0}) begin
      n_fails++;
      $display("FAIL reset: z=%h v=%b f=%b ready=%b done=%b, expected all 0 with ready=1",
               z_data, z_valid, z_flag, lready, ldone);
    end
  endtask

  task automatic test_load();
    logic [31:0] w [4];
    w[0] = 10; w[1] = 20; w[2] = 30; w[3] = 40;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (lready !== 1'b1) begin
        n_fails++;
        $display("FAIL load_ready word %0d: ready=%b, expected 1", i, lready);
      end
      step(4'b0, '0, 1'b1, w[i], 1'b0, 1'b1, 1'b0);
    end
    n_checks++;
    if ({ldone, lready} !== 2'b10) begin
      n_fails++;
      $display("FAIL load_full: done=%b ready=%b, expected done=1 ready=0", ldone, lready);
    end
    step(4'b0, '0, 1'b1, 32'd999, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({ldone, lready} !== 2'b10) begin
      n_fails++;
      $display("FAIL load_extra: done=%b ready=%b, expected done=1 ready=0", ldone, lready);
    end
  endtask

  task automatic test_swap_add();
    step(4'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({ldone, lready} !== 2'b01) begin
      n_fails++;
      $display("FAIL swap_state: done=%b ready=%b, expected done=0 ready=1", ldone, lready);
    end
    step(4'b1111, pack4(5, 6, 7, 8), 1'b0, '0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({z_data, z_valid, z_flag} !== {pack4(15, 26, 37, 48), 4'b1111, 4'b0000}) begin
      n_fails++;
      $display("FAIL swap_add: z=%h v=%b f=%b, expected z=%h v=1111 f=0000",
               z_data, z_valid, z_flag, pack4(15, 26, 37, 48));
    end
  endtask

  task automatic test_swap_boundary();
    load4(1, 1, 1, 1);
    step(4'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    load4(100, 100, 100, 100);
    step(4'b1111, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (z_data !== pack4(1, 1, 1, 1) || z_data !== exp_z()) begin
      n_fails++;
      $display("FAIL swap_edge_old: z=%h, expected %h", z_data, pack4(1, 1, 1, 1));
    end
    step(4'b1111, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (z_data !== pack4(100, 100, 100, 100)) begin
      n_fails++;
      $display("FAIL swap_edge_new: z=%h, expected %h", z_data, pack4(100, 100, 100, 100));
    end
  endtask

  task automatic test_skew();
    logic [3:0] pat [4];
    pat[0] = 4'b0001; pat[1] = 4'b0011; pat[2] = 4'b0110; pat[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step(pat[i], pack4(1, 1, 1, 1), 1'b0, '0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (z_valid !== pat[i] || z_data !== exp_z() || z_flag !== m_f) begin
        n_fails++;
        $display("FAIL skew %0d: v=%b z=%h, expected v=%b z=%h", i, z_valid, z_data, pat[i], exp_z());
      end
    end
  endtask

  task automatic test_saturation();
    load4(1, 32'hFFFF_FFFF, 0, 0);
    step(4'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(4'b0011, pack4(32'h7FFF_FFFF, 32'h8000_0000, 0, 0), 1'b0, '0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (z_data[63:0] !== {32'h8000_0000, 32'h7FFF_FFFF} || z_flag[1:0] !== 2'b11) begin
      n_fails++;
      $display("FAIL sat_on: z=%h f=%b, expected 80000000_7fffffff f=11", z_data[63:0], z_flag[1:0]);
    end
    step(4'b0011, pack4(32'h7FFF_FFFF, 32'h8000_0000, 0, 0), 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (z_data[63:0] !== {32'h7FFF_FFFF, 32'h8000_0000} || z_flag[1:0] !== 2'b00) begin
      n_fails++;
      $display("FAIL sat_off: z=%h f=%b, expected 7fffffff_80000000 f=00", z_data[63:0], z_flag[1:0]);
    end
  endtask

  task automatic test_midload_reset();
    step(4'b0, '0, 1'b1, 32'd55, 1'b0, 1'b1, 1'b0);
    step(4'b0, '0, 1'b1, 32'd66, 1'b0, 1'b1, 1'b0);
    step(4'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (z_valid !== 4'b0 || ldone !== 1'b0) begin
      n_fails++;
      $display("FAIL midreset: v=%b done=%b, expected 0000 and 0", z_valid, ldone);
    end
    step(4'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(4'b1111, pack4(3, 4, 5, 6), 1'b0, '0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (z_data !== pack4(3, 4, 5, 6) || ldone !== 1'b0 || lready !== 1'b1) begin
      n_fails++;
      $display("FAIL ignored_swap: z=%h done=%b ready=%b, expected %h done=0 ready=1",
               z_data, ldone, lready, pack4(3, 4, 5, 6));
    end
    load4(7, 8, 9, 10);
    step(4'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(4'b1111, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (z_data !== pack4(7, 8, 9, 10)) begin
      n_fails++;
      $display("FAIL reload_col0: z=%h, expected %h", z_data, pack4(7, 8, 9, 10));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [127:0] d;
      logic [31:0]  ld;
      for (int c = 0; c < N; c++) begin
        case ($urandom_range(0, 3))
          0:       d[c*32 +: 32] = 32'h7FFF_FFF0 + 32'($urandom_range(0, 31));
          1:       d[c*32 +: 32] = 32'h8000_0000 + 32'($urandom_range(0, 31));
          default: d[c*32 +: 32] = $urandom;
        endcase
      end
      ld = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      step(4'($urandom), d, 1'($urandom), ld, ($urandom_range(0, 3) == 0),
           1'($urandom), ($urandom_range(0, 99) == 0));
      n_checks++;
      if (z_data !== exp_z() || z_valid !== m_v || z_flag !== m_f ||
          ldone !== m_full || lready !== !m_full) begin
        n_fails++;
        $display("FAIL random %0d: z=%h v=%b f=%b done=%b ready=%b, expected z=%h v=%b f=%b done=%b",
                 i, z_data, z_valid, z_flag, ldone, lready, exp_z(), m_v, m_f, m_full);
      end
    end
  endtask

  initial begin
    rst = 1'b1; lvalid = 1'b0; ldata = '0; swap = 1'b0; sat_en = 1'b1;
    sys_data = '0; sys_valid = '0;
    m_cnt = 0; m_full = 0; m_v = '0; m_f = '0;
    for (int c = 0; c < N; c++) begin
      m_active[c] = 0; m_shadow[c] = 0; m_z[c] = '0;
    end
    @(negedge clk);
    test_reset();
    test_load();
    test_swap_add();
    test_swap_boundary();
    test_skew();
    test_saturation();
    test_midload_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
